grid_bank_scheduler: RTL

GRID_BANK_SCHEDULER -- requirements
Module: grid_bank_scheduler

---
 rtl/grid_bank_scheduler.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/grid_bank_scheduler.sv
// Ping-pong scheduler for two grid RAM banks: the writer fills one bank while
// the reader runs statistics on the other, and a clear engine zeroes each bank
// after it is read so that it can be filled again.
module grid_bank_scheduler #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 48
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              enable_i,
  input  logic              wr_frame_done_i,
  input  logic              rd_done_i,
  output logic              wr_bank_o,
  output logic              wr_allow_o,
  output logic              tannis_change_o,
  output logic              rd_start_o,
  output logic              rd_bank_o,
  output logic              rd_busy_o,
  output logic              clr_wren_o,
  output logic              clr_bank_o,
  output logic [ADDR_W-1:0] clr_addr_o,
  output logic [DATA_W-1:0] clr_data_o,
  output logic [15:0]       drop_cnt_o,
  output logic [2:0]        bank0_state_o,
  output logic [2:0]        bank1_state_o
);

  typedef enum logic [2:0] {
    FREE  = 3'd0,
    FILL  = 3'd1,
    FULL  = 3'd2,
    READ  = 3'd3,
    CLEAR = 3'd4
  } bank_state_e;

  bank_state_e       bank_q [2];
  bank_state_e       bank_d [2];
  logic              wr_bank_q, wr_bank_d;
  logic              stalled_q, stalled_d;
  logic              last_full_q, last_full_d;
  logic              tc_q, tc_d;
  logic              rd_start_q, rd_start_d;
  logic              rd_bank_q, rd_bank_d;
  logic              rd_busy_q, rd_busy_d;
  logic              clr_active_q, clr_active_d;
  logic              clr_bank_q, clr_bank_d;
  logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;
  logic [15:0]       drop_q, drop_d;
  logic              other;
  logic              pick;

  // Next-state logic; the writer, dispatcher, read-completion and clear
  // engine each touch a different bank, so their updates never collide.
  always_comb begin
    bank_d[0]    = bank_q[0];
    bank_d[1]    = bank_q[1];
    wr_bank_d    = wr_bank_q;
    stalled_d    = stalled_q;
    last_full_d  = last_full_q;
    tc_d         = 1'b0;
    rd_start_d   = 1'b0;
    rd_bank_d    = rd_bank_q;
    rd_busy_d    = rd_busy_q;
    clr_active_d = clr_active_q;
    clr_bank_d   = clr_bank_q;
    clr_addr_d   = clr_addr_q;
    drop_d       = drop_q;
    other        = ~wr_bank_q;
    pick         = 1'b0;

    if (!stalled_q) begin
      if (wr_frame_done_i) begin
        bank_d[wr_bank_q] = FULL;
        last_full_d       = wr_bank_q;
        if (bank_q[other] == FREE) begin
          bank_d[other] = FILL;
          wr_bank_d     = other;
          tc_d          = 1'b1;
        end else begin
          stalled_d = 1'b1;
        end
      end
    end else begin
      if (wr_frame_done_i && drop_q != 16'hFFFF)
        drop_d = drop_q + 16'd1;
      if (bank_q[0] == FREE) begin
        bank_d[0] = FILL;
        wr_bank_d = 1'b0;
        stalled_d = 1'b0;
        tc_d      = 1'b1;
      end else if (bank_q[1] == FREE) begin
        bank_d[1] = FILL;
        wr_bank_d = 1'b1;
        stalled_d = 1'b0;
        tc_d      = 1'b1;
      end
    end

    if (enable_i && !rd_busy_q && !clr_active_q &&
        (bank_q[0] == FULL || bank_q[1] == FULL)) begin
      if (bank_q[0] == FULL && bank_q[1] == FULL)
        pick = ~last_full_q;
      else
        pick = (bank_q[1] == FULL);
      bank_d[pick] = READ;
      rd_bank_d    = pick;
      rd_busy_d    = 1'b1;
      rd_start_d   = 1'b1;
    end

    if (rd_done_i && rd_busy_q) begin
      bank_d[rd_bank_q] = CLEAR;
      rd_busy_d         = 1'b0;
      clr_active_d      = 1'b1;
      clr_bank_d        = rd_bank_q;
      clr_addr_d        = '0;
    end

    if (clr_active_q) begin
      if (clr_addr_q == {ADDR_W{1'b1}}) begin
        clr_active_d       = 1'b0;
        bank_d[clr_bank_q] = FREE;
        clr_addr_d         = '0;
      end else begin
        clr_addr_d = clr_addr_q + 1'b1;
      end
    end
  end

  // State registers; reset abandons any read or clear in flight.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      bank_q[0]    <= FILL;
      bank_q[1]    <= FREE;
      wr_bank_q    <= 1'b0;
      stalled_q    <= 1'b0;
      last_full_q  <= 1'b0;
      tc_q         <= 1'b0;
      rd_start_q   <= 1'b0;
      rd_bank_q    <= 1'b0;
      rd_busy_q    <= 1'b0;
      clr_active_q <= 1'b0;
      clr_bank_q   <= 1'b0;
      clr_addr_q   <= '0;
      drop_q       <= 16'd0;
    end else begin
      bank_q[0]    <= bank_d[0];
      bank_q[1]    <= bank_d[1];
      wr_bank_q    <= wr_bank_d;
      stalled_q    <= stalled_d;
      last_full_q  <= last_full_d;
      tc_q         <= tc_d;
      rd_start_q   <= rd_start_d;
      rd_bank_q    <= rd_bank_d;
      rd_busy_q    <= rd_busy_d;
      clr_active_q <= clr_active_d;
      clr_bank_q   <= clr_bank_d;
      clr_addr_q   <= clr_addr_d;
      drop_q       <= drop_d;
    end
  end

  assign wr_bank_o       = wr_bank_q;
  assign wr_allow_o      = ~stalled_q;
  assign tannis_change_o = tc_q;
  assign rd_start_o      = rd_start_q;
  assign rd_bank_o       = rd_bank_q;
  assign rd_busy_o       = rd_busy_q;
  assign clr_wren_o      = clr_active_q;
  assign clr_bank_o      = clr_bank_q;
  assign clr_addr_o      = clr_addr_q;
  assign clr_data_o      = '0;
  assign drop_cnt_o      = drop_q;
  assign bank0_state_o   = bank_q[0];
  assign bank1_state_o   = bank_q[1];

endmodule
